// File: rtl/inst_issue_if.sv
// Issue-side bundle of inst_issue: instruction ROM read port, CU issue bus and run control.
// master = sequencer side, slave = ROM/CU/environment side.
interface inst_issue_if #(
  parameter int PC_WIDTH   = 8,
  parameter int INST_WIDTH = 16
);
  logic                  start;
  logic                  imem_rd_en;
  logic [PC_WIDTH-1:0]   imem_addr;
  logic [INST_WIDTH-1:0] imem_data;
  logic                  stall;
  logic [3:0]            op_code;
  logic [3:0]            rd_idx;
  logic [7:0]            operand;
  logic                  op_valid;
  logic [PC_WIDTH-1:0]   pc;
  logic                  halted;

  modport master (
    input  start, imem_data, stall,
    output imem_rd_en, imem_addr, op_code, rd_idx, operand, op_valid, pc, halted
  );

  modport slave (
    output start, imem_data, stall,
    input  imem_rd_en, imem_addr, op_code, rd_idx, operand, op_valid, pc, halted
  );
endinterface

// File: rtl/inst_issue.sv
// Instruction fetch/issue sequencer: FETCH -> WAIT -> ISSUE per word, stall-held issue, HALT on 0xF.
// Optional build macro INST_ISSUE_BRANCH_EN: opcode 0101 becomes an internal jump (NOP slot issued).
module inst_issue #(
  parameter int                     PC_WIDTH   = 8,
  parameter int                     INST_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]    RESET_PC   = '0
) (
  input  logic        clk,
  input  logic        rst,
  inst_issue_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_ISSUE, S_HALT} state_t;

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_ADDI = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_LD   = 4'b0100;
  localparam logic [3:0] OP_JMP  = 4'b0101;
  localparam logic [3:0] OP_HALT = 4'b1111;

  state_t                state;
  logic [PC_WIDTH-1:0]   pc_q;
  logic [INST_WIDTH-1:0] ir;
  logic [3:0]            op_code_q;
  logic                  op_valid_q;
  logic                  rd_en_q;
  logic [PC_WIDTH-1:0]   addr_q;
  logic                  halted_q;
  logic [PC_WIDTH-1:0]   next_pc;

  // Only the four datapath opcodes reach the CU; everything else is a NOP slot.
  function automatic logic [3:0] issue_op(input logic [3:0] op);
    case (op)
      OP_ADD, OP_ADDI, OP_ST, OP_LD: return op;
      default:                       return 4'b0000;
    endcase
  endfunction

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    next_pc = pc_q + PC_WIDTH'(1);
`ifdef INST_ISSUE_BRANCH_EN
    if (ir[15:12] == OP_JMP)
      next_pc = PC_WIDTH'(ir[7:0]);
`else
    if (ir[15:12] == OP_JMP)
      next_pc = pc_q + PC_WIDTH'(1);
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pc_q       <= RESET_PC;
      ir         <= '0;
      op_code_q  <= 4'b0000;
      op_valid_q <= 1'b0;
      rd_en_q    <= 1'b0;
      addr_q     <= RESET_PC;
      halted_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state   <= S_FETCH;
            rd_en_q <= 1'b1;
            addr_q  <= pc_q;
          end
        end
        S_FETCH: begin
          rd_en_q <= 1'b0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          ir <= bus.imem_data;
          if (bus.imem_data[15:12] == OP_HALT) begin
            state    <= S_HALT;
            halted_q <= 1'b1;
          end else begin
            state      <= S_ISSUE;
            op_valid_q <= 1'b1;
            op_code_q  <= issue_op(bus.imem_data[15:12]);
          end
        end
        S_ISSUE: begin
          // Downstream accepts on the first cycle without stall; the next fetch starts at once.
          if (!bus.stall) begin
            op_valid_q <= 1'b0;
            op_code_q  <= 4'b0000;
            pc_q       <= next_pc;
            addr_q     <= next_pc;
            rd_en_q    <= 1'b1;
            state      <= S_FETCH;
          end
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.imem_rd_en = rd_en_q;
  assign bus.imem_addr  = addr_q;
  assign bus.op_code    = op_code_q;
  assign bus.rd_idx     = ir[11:8];
  assign bus.operand    = ir[7:0];
  assign bus.op_valid   = op_valid_q;
  assign bus.pc         = pc_q;
  assign bus.halted     = halted_q;

endmodule

// File: tb/tb_inst_issue.sv
// Scoreboard bench for inst_issue: stimulus pushes expected issue slots, a negedge monitor pops them.
// Two instances: dut0 with RESET_PC=0, dut1 with RESET_PC=255 for the pc wrap case.
module tb_inst_issue;

  typedef struct {
    logic [3:0] op;
    logic [3:0] rd;
    logic [7:0] opnd;
    logic [7:0] pc;
    int         gap;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   cycle  = 0;

  logic [15:0] rom0 [256];
  logic [15:0] rom1 [256];
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  logic prev0 = 1'b0, prev1 = 1'b0;
  int   last0 = 0, last1 = 0;

  inst_issue_if #(.PC_WIDTH(8), .INST_WIDTH(16)) bus0 ();
  inst_issue_if #(.PC_WIDTH(8), .INST_WIDTH(16)) bus1 ();

  inst_issue #(.PC_WIDTH(8), .INST_WIDTH(16), .RESET_PC(8'd0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  inst_issue #(.PC_WIDTH(8), .INST_WIDTH(16), .RESET_PC(8'd255)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Synchronous ROMs: data appears the cycle after the read enable.
  always @(posedge clk) begin
    if (bus0.imem_rd_en) bus0.imem_data <= rom0[bus0.imem_addr];
    if (bus1.imem_rd_en) bus1.imem_data <= rom1[bus1.imem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic cmp_issue(input string who, input exp_t e, input logic [3:0] op,
                           input logic [3:0] rd, input logic [7:0] opnd, input logic [7:0] pc);
    check({who, " op_code"}, op, e.op);
    check({who, " rd_idx"}, rd, e.rd);
    check({who, " operand"}, opnd, e.opnd);
    check({who, " pc at issue"}, pc, e.pc);
  endtask

  // Monitor: compare every valid cycle against the queue head (stall cycles check stability).
  always @(negedge clk) begin
    if (rst) begin
      prev0 = 1'b0;
      prev1 = 1'b0;
    end else begin
      if (bus0.op_valid) begin
        if (q0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dut0 unexpected issue: got op=%0h rd=%0h opnd=%0h expected none",
                   bus0.op_code, bus0.rd_idx, bus0.operand);
        end else begin
          e0 = q0[0];
          cmp_issue("dut0", e0, bus0.op_code, bus0.rd_idx, bus0.operand, bus0.pc);
          if (!prev0 && e0.gap != 0) check("dut0 issue spacing", cycle - last0, e0.gap);
          if (!bus0.stall) void'(q0.pop_front());
        end
        if (!prev0) last0 = cycle;
      end else begin
        check("dut0 op_code idle", bus0.op_code, 4'h0);
      end
      prev0 = bus0.op_valid;

      if (bus1.op_valid) begin
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dut1 unexpected issue: got op=%0h rd=%0h opnd=%0h expected none",
                   bus1.op_code, bus1.rd_idx, bus1.operand);
        end else begin
          e1 = q1[0];
          cmp_issue("dut1", e1, bus1.op_code, bus1.rd_idx, bus1.operand, bus1.pc);
          if (!prev1 && e1.gap != 0) check("dut1 issue spacing", cycle - last1, e1.gap);
          if (!bus1.stall) void'(q1.pop_front());
        end
        if (!prev1) last1 = cycle;
      end else begin
        check("dut1 op_code idle", bus1.op_code, 4'h0);
      end
      prev1 = bus1.op_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    bus0.stall = 1'b0;
    bus1.stall = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    q0.delete();
    q1.delete();
  endtask

  task automatic fill_roms();
    for (int i = 0; i < 256; i++) begin
      rom0[i] = 16'hF000;
      rom1[i] = 16'hF000;
    end
  endtask

  task automatic push0(input logic [3:0] op, input logic [3:0] rd, input logic [7:0] opnd,
                       input logic [7:0] pc, input int gap);
    exp_t e;
    e.op = op; e.rd = rd; e.opnd = opnd; e.pc = pc; e.gap = gap;
    q0.push_back(e);
  endtask

  task automatic wait_halt(input int which, input int budget);
    for (int i = 0; i < budget; i++) begin
      if ((which == 0 && bus0.halted) || (which == 1 && bus1.halted)) break;
      tick();
    end
    check(which == 0 ? "dut0 reached HALT" : "dut1 reached HALT",
          which == 0 ? bus0.halted : bus1.halted, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fill_roms();
    do_reset();

    // Idle after reset: nothing moves without start.
    for (int i = 0; i < 5; i++) begin
      check("idle op_valid", bus0.op_valid, 1'b0);
      check("idle imem_rd_en", bus0.imem_rd_en, 1'b0);
      check("idle pc", bus0.pc, 8'd0);
      check("idle imem_addr", bus0.imem_addr, 8'd0);
      check("idle halted", bus0.halted, 1'b0);
      check("idle dut1 pc", bus1.pc, 8'd255);
      tick();
    end

    // rst and start together: rst wins, no fetch starts.
    rst = 1'b1;
    bus0.start = 1'b1;
    tick();
    rst = 1'b0;
    bus0.start = 1'b0;
    check("rst+start imem_rd_en", bus0.imem_rd_en, 1'b0);
    tick();
    check("rst+start stays idle", bus0.imem_rd_en, 1'b0);

    // Two instructions then halt; second issue 3 cycles after the first.
    do_reset();
    rom0[0] = 16'h1123;
    rom0[1] = 16'h2205;
    rom0[2] = 16'hF000;
    push0(4'h1, 4'h1, 8'h23, 8'd0, 0);
    push0(4'h2, 4'h2, 8'h05, 8'd1, 3);
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    wait_halt(0, 40);
    check("prog A halt pc", bus0.pc, 8'd2);
    check("prog A all issued", q0.size(), 0);
    bus0.start = 1'b1;
    repeat (3) tick();
    bus0.start = 1'b0;
    check("start ignored in HALT", bus0.halted, 1'b1);
    check("HALT pc held", bus0.pc, 8'd2);
    check("HALT no fetch", bus0.imem_rd_en, 1'b0);

    // Stall held for 4 ISSUE cycles: fields stable 5 cycles, pc held then advances.
    do_reset();
    fill_roms();
    rom0[0] = 16'h3107;
    push0(4'h3, 4'h1, 8'h07, 8'd0, 0);
    bus0.stall = 1'b1;
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus0.op_valid) break;
      tick();
    end
    check("stall issue seen", bus0.op_valid, 1'b1);
    repeat (4) tick();
    check("stall pc held", bus0.pc, 8'd0);
    bus0.stall = 1'b0;
    tick();
    check("stall pc advanced", bus0.pc, 8'd1);
    wait_halt(0, 20);
    check("stall all issued", q0.size(), 0);

    // Unknown opcode issues as NOP with fields intact.
    do_reset();
    rom0[0] = 16'h7AAA;
    push0(4'h0, 4'hA, 8'hAA, 8'd0, 0);
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    wait_halt(0, 20);
    check("nop halt pc", bus0.pc, 8'd1);
    check("nop all issued", q0.size(), 0);

    // Jump opcode: NOP slot either way; pc target depends on the build option.
    do_reset();
    rom0[0] = 16'h5010;
    push0(4'h0, 4'h0, 8'h10, 8'd0, 0);
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    wait_halt(0, 20);
`ifdef INST_ISSUE_BRANCH_EN
    check("jmp target pc", bus0.pc, 8'd16);
`else
    check("jmp as nop pc", bus0.pc, 8'd1);
`endif
    check("jmp all issued", q0.size(), 0);

    // Wrap from 255 to 0 on the second instance.
    do_reset();
    rom1[255] = 16'h4101;
    rom1[0]   = 16'hF000;
    begin
      exp_t e;
      e.op = 4'h4; e.rd = 4'h1; e.opnd = 8'h01; e.pc = 8'd255; e.gap = 0;
      q1.push_back(e);
    end
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    wait_halt(1, 20);
    check("wrap halt pc", bus1.pc, 8'd0);
    check("wrap all issued", q1.size(), 0);

    // Reset while the second word is in WAIT: back to IDLE at RESET_PC, IR cleared.
    do_reset();
    rom0[0] = 16'h1123;
    rom0[1] = 16'h2205;
    push0(4'h1, 4'h1, 8'h23, 8'd0, 0);
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus0.op_valid) break;
      tick();
    end
    check("pre-reset issue seen", bus0.op_valid, 1'b1);
    tick();
    check("pre-reset fetch pc", bus0.pc, 8'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid-WAIT reset pc", bus0.pc, 8'd0);
    check("mid-WAIT reset imem_addr", bus0.imem_addr, 8'd0);
    check("mid-WAIT reset op_valid", bus0.op_valid, 1'b0);
    check("mid-WAIT reset imem_rd_en", bus0.imem_rd_en, 1'b0);
    check("mid-WAIT reset rd_idx", bus0.rd_idx, 4'h0);
    check("mid-WAIT reset operand", bus0.operand, 8'h00);
    check("mid-WAIT reset halted", bus0.halted, 1'b0);
    repeat (5) tick();
    check("post-reset stays idle", bus0.imem_rd_en, 1'b0);
    check("post-reset queue drained", q0.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
